alu_seq: RTL and testbench

Parametrised, registered ALU for the CPU datapath. It is the successor to the 8-bit ALU, with these additions:
- parametrised word width
- INC/DEC, shifts, rotate-through-carry, CMP and carry-chained ADC/SBB
- full N/Z/C/V flags
- a multi-cycle shift-add multiplier with a busy/done handshake

The result register drives the shared tri-state data bus under output enable.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 207 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq bus bundle: operands, mode, ee/eo strobes, flags, busy/done.
// master drives operands and strobes; slave (the ALU) returns flags and status.
`timescale 1ns/1ps
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       mode;
  logic             ee;
  logic             eo;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_neg;
  logic             flag_ovf;
  logic             busy;
  logic             done;

  modport master (
    output in_a, in_b, mode, ee, eo,
    input  flag_zero, flag_carry, flag_neg, flag_ovf, busy, done
  );

  modport slave (
    input  in_a, in_b, mode, ee, eo,
    output flag_zero, flag_carry, flag_neg, flag_ovf, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with NZCV flags and shift-add multiplier (busy/done).
// Ports: clk, rst_n, bus (alu_seq_if.slave), out (tri-state result bus).
`timescale 1ns/1ps
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_seq_if.slave        bus,
  inout  wire [WIDTH-1:0] out
);
  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] r_q;
  logic             z_q, n_q, c_q, v_q;
  logic             done_q;

  logic [2*WIDTH-1:0] mcand, acc, addend, prod;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               mhigh;
  logic               last;
  logic               start_mul;

  logic [15:0]      op;
  logic [WIDTH-1:0] opb;
  logic             cin;
  logic [WIDTH:0]   add_s, sub_d;
  logic             add_v, sub_v;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v;

  logic             busy;
  logic             fire, wr_r, wr_f;
  logic [WIDTH-1:0] res, zv;
  logic             c_n, v_n;

  assign op = 16'd1 << bus.mode;

  // INC/DEC reuse the adder/subtractor with B forced to one
  assign opb = (op[4] | op[5]) ? ONE : bus.in_b;
  assign cin = (op[1] | op[3]) ? c_q : 1'b0;

  assign add_s = {1'b0, bus.in_a} + {1'b0, opb}
               + {{WIDTH{1'b0}}, cin};
  assign sub_d = {1'b0, bus.in_a} - {1'b0, opb}
               - {{WIDTH{1'b0}}, cin};

  assign add_v = (bus.in_a[M] == opb[M])
               && (add_s[M] != bus.in_a[M]);
  assign sub_v = (bus.in_a[M] != opb[M])
               && (sub_d[M] != bus.in_a[M]);

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (1'b1)
      op[0], op[1], op[4]: begin
        alu_r = add_s[M:0];
        alu_c = add_s[WIDTH];
        alu_v = add_v;
      end
      op[2], op[3], op[5], op[13]: begin
        alu_r = sub_d[M:0];
        alu_c = sub_d[WIDTH];
        alu_v = sub_v;
      end
      op[6]:  alu_r = bus.in_a & bus.in_b;
      op[7]:  alu_r = bus.in_a | bus.in_b;
      op[8]:  alu_r = bus.in_a ^ bus.in_b;
      op[9]:  alu_r = ~bus.in_a;
      op[10]: begin
        alu_r = {bus.in_a[M-1:0], 1'b0};
        alu_c = bus.in_a[M];
      end
      op[11]: begin
        alu_r = {1'b0, bus.in_a[M:1]};
        alu_c = bus.in_a[0];
      end
      op[12]: begin
        alu_r = {bus.in_a[M-1:0], c_q};
        alu_c = bus.in_a[M];
      end
      default: ;
    endcase
  end

  assign start_mul = (state == IDLE) && bus.ee
                   && (op[14] | op[15]) && (MUL_EN != 0);
  assign last   = (cnt == LAST);
  assign addend = mplier[0] ? mcand : '0;
  assign prod   = acc + addend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start_mul) state_n = MUL_RUN;
      MUL_RUN: if (last)      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    fire = 1'b0;
    wr_r = 1'b0;
    wr_f = 1'b0;
    res  = '0;
    zv   = '0;
    c_n  = c_q;
    v_n  = v_q;
    unique case (state)
      IDLE: begin
        if (bus.ee && !start_mul) begin
          fire = 1'b1;
          // MUL/MULH with the multiplier absent: done only
          if (!(op[14] | op[15])) begin
            wr_f = 1'b1;
            wr_r = !op[13];
            res  = alu_r;
            zv   = alu_r;
            c_n  = alu_c;
            v_n  = alu_v;
          end
        end
      end
      MUL_RUN: begin
        busy = 1'b1;
        if (last) begin
          fire = 1'b1;
          wr_f = 1'b1;
          wr_r = 1'b1;
          res  = mhigh ? prod[2*WIDTH-1:WIDTH]
                       : prod[M:0];
          zv   = res;
          c_n  = |prod[2*WIDTH-1:WIDTH];
          v_n  = |prod[2*WIDTH-1:WIDTH];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      mhigh  <= 1'b0;
    end else if (start_mul) begin
      mcand  <= {{WIDTH{1'b0}}, bus.in_a};
      mplier <= bus.in_b;
      acc    <= '0;
      cnt    <= '0;
      mhigh  <= bus.mode[0];
    end else if (state == MUL_RUN) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= fire;
      if (wr_r) r_q <= res;
      if (wr_f) begin
        z_q <= (zv == '0);
        n_q <= zv[M];
        c_q <= c_n;
        v_q <= v_n;
      end
    end
  end

  assign out = bus.eo ? r_q : 'z;

  assign bus.flag_zero  = z_q;
  assign bus.flag_neg   = n_q;
  assign bus.flag_carry = c_q;
  assign bus.flag_ovf   = v_q;
  assign bus.busy       = busy;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: random ops scored against an arithmetic model.
// Directed cases cover carry chains, overflow, shifts, CMP, multiply, bus, reset.
`timescale 1ns/1ps
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  b8 ();
  alu_seq_if #(.WIDTH(16)) b16 ();

  wire [7:0]  out8;
  wire [15:0] out16;
  logic       tb_drv = 1'b0;
  logic [7:0] tb_val = 8'h00;
  assign out8 = tb_drv ? tb_val : 8'bz;

  alu_seq #(.WIDTH(8), .MUL_EN(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8), .out(out8)
  );
  alu_seq #(.WIDTH(16), .MUL_EN(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(b16), .out(out16)
  );

  typedef struct packed {
    logic [7:0] r;
    logic z, n, c, v;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_r;
  logic m_z, m_n, m_c, m_v;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic expect_now(input string name, input logic [7:0] r,
                            input logic z, n, c, v);
    check(name,
          {20'h0, out8, b8.flag_zero, b8.flag_neg,
           b8.flag_carry, b8.flag_ovf},
          {20'h0, r, z, n, c, v});
  endtask

  function automatic void model(input logic [3:0] m,
                                input logic [7:0] a, b);
    int ua, ub, sa, sb, ci, u, s, res;
    logic c, v, wr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = m_c ? 1 : 0;
    u = 0; s = 0; c = 1'b0; v = 1'b0; wr = 1'b1;
    case (m)
      4'd0:  begin u = ua + ub;      s = sa + sb;      c = (u > 255); end
      4'd1:  begin u = ua + ub + ci; s = sa + sb + ci; c = (u > 255); end
      4'd2:  begin u = ua - ub;      s = sa - sb;      c = (u < 0);   end
      4'd3:  begin u = ua - ub - ci; s = sa - sb - ci; c = (u < 0);   end
      4'd4:  begin u = ua + 1;       s = sa + 1;       c = (u > 255); end
      4'd5:  begin u = ua - 1;       s = sa - 1;       c = (u < 0);   end
      4'd6:  u = ua & ub;
      4'd7:  u = ua | ub;
      4'd8:  u = ua ^ ub;
      4'd9:  u = 255 - ua;
      4'd10: begin u = ua * 2;      c = (ua >= 128);  end
      4'd11: begin u = ua / 2;      c = (ua % 2 == 1); end
      4'd12: begin u = ua * 2 + ci; c = (ua >= 128);  end
      4'd13: begin u = ua - ub; s = sa - sb; c = (u < 0); wr = 1'b0; end
      default: begin
        u = ua * ub;
        c = (u > 255);
        v = c;
        if (m == 4'd15) u = u / 256;
      end
    endcase
    if (m <= 4'd5 || m == 4'd13) v = (s > 127) || (s < -128);
    res = u & 255;
    if (wr) m_r = 8'(res);
    m_z = (res == 0);
    m_n = (res >= 128);
    m_c = c;
    m_v = v;
    q.push_back('{m_r, m_z, m_n, m_c, m_v});
  endfunction

  task automatic issue(input logic [3:0] m, input logic [7:0] a, b,
                       input bit poke);
    logic [7:0] old_r;
    int n;
    old_r = m_r;
    model(m, a, b);
    @(negedge clk);
    b8.mode = m;
    b8.in_a = a;
    b8.in_b = b;
    b8.ee   = 1'b1;
    @(negedge clk);
    b8.ee = 1'b0;
    if (m >= 4'd14) begin
      check("bus_old_during_mul", {24'h0, out8}, {24'h0, old_r});
      n = 0;
      while (b8.busy && n < 40) begin
        n++;
        // ee and operand changes while busy must be ignored
        if (poke && n == 2) begin
          b8.ee   = 1'b1;
          b8.mode = 4'd0;
          b8.in_a = 8'($urandom);
          b8.in_b = 8'($urandom);
        end
        @(negedge clk);
      end
      b8.ee = 1'b0;
      check("mul_busy_cycles", n, 8);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b8.done) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, want no pending op");
      end else begin
        e = q.pop_front();
        check("scoreboard",
              {20'h0, out8, b8.flag_zero, b8.flag_neg,
               b8.flag_carry, b8.flag_ovf},
              {20'h0, e});
      end
    end
  end

  initial begin
    int n;
    b8.in_a = '0; b8.in_b = '0; b8.mode = '0;
    b8.ee = 1'b0; b8.eo = 1'b1;
    b16.in_a = '0; b16.in_b = '0; b16.mode = '0;
    b16.ee = 1'b0; b16.eo = 1'b1;
    m_r = '0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_state",
          {24'h0, out8, b8.flag_zero, b8.flag_neg, b8.flag_carry,
           b8.flag_ovf, b8.busy, b8.done},
          32'h0);
    rst_n = 1'b1;

    issue(4'd0, 8'hFF, 8'h01, 1'b0);
    expect_now("add_ff_01", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(4'd1, 8'h00, 8'h00, 1'b0);
    expect_now("adc_chain", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd0, 8'h7F, 8'h01, 1'b0);
    expect_now("add_ovf", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(4'd2, 8'h80, 8'h01, 1'b0);
    expect_now("sub_ovf", 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'd2, 8'h00, 8'h01, 1'b0);
    expect_now("sub_borrow", 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
    issue(4'd5, 8'h00, 8'h00, 1'b0);
    expect_now("dec_zero", 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
    issue(4'd10, 8'h81, 8'h00, 1'b0);
    expect_now("shl_81", 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(4'd12, 8'h40, 8'h00, 1'b0);
    expect_now("rol_40_c1", 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(4'd13, 8'h05, 8'h05, 1'b0);
    expect_now("cmp_equal", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(4'd14, 8'hFF, 8'hFF, 1'b1);
    expect_now("mul_ff_ff", 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(4'd15, 8'hFF, 8'hFF, 1'b1);
    expect_now("mulh_ff_ff", 8'hFE, 1'b0, 1'b1, 1'b1, 1'b1);

    @(negedge clk);
    b8.eo = 1'b0;
    @(negedge clk);
    tb_val = 8'h5A;
    tb_drv = 1'b1;
    #1;
    check("bus_released", {24'h0, out8}, 32'h5A);
    @(negedge clk);
    tb_drv = 1'b0;
    b8.eo  = 1'b1;
    #1;
    check("bus_driven", {24'h0, out8}, {24'h0, m_r});

    @(negedge clk);
    b8.mode = 4'd14;
    b8.in_a = 8'd15;
    b8.in_b = 8'd17;
    b8.ee   = 1'b1;
    @(negedge clk);
    b8.ee = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_mul",
          {24'h0, out8, b8.flag_zero, b8.flag_neg, b8.flag_carry,
           b8.flag_ovf, b8.busy, b8.done},
          32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_r = '0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
    issue(4'd0, 8'h01, 8'h01, 1'b0);
    expect_now("add_after_reset", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (150) begin
      issue(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    b16.mode = 4'd14;
    b16.in_a = 16'h0100;
    b16.in_b = 16'h0100;
    b16.ee   = 1'b1;
    @(negedge clk);
    b16.ee = 1'b0;
    n = 0;
    while (b16.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("mul16_busy_cycles", n, 16);
    check("mul16_result",
          {12'h0, out16, b16.flag_zero, b16.flag_neg,
           b16.flag_carry, b16.flag_ovf},
          {12'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1});

    n = 0;
    while (q.size() != 0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
